// File: rtl/lstm_host_pkg.sv
// Shared definitions for the host-side LSTM initialisation path.
package lstm_host_pkg;

    // Bytes carried by one 256-bit packed init word.
    localparam int INIT_BYTES_PER_WORD = 32;

    // Default geometry shared with the LSTM core.
    localparam int LSTM_W_WORDS = 2048;
    localparam int LSTM_B_WORDS = 32;

    // Streamer control states.
    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        STREAM,
        WAIT_DONE,
        DONE,
        ERR
    } init_state_t;

endpackage

// File: rtl/lstm_init_word_buf.sv
// One-entry host word buffer with ready generation and a same-cycle bypass
// path, so a word arriving exactly when the shifter needs it does not stall.
module lstm_init_word_buf #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iEnable,     // controller is in a word-accepting state
    input  logic             iRoom,       // more words are still wanted
    input  logic             iWord_valid,
    input  logic [WIDTH-1:0] iWord_data,
    input  logic             iTake,       // consumer takes the available word this cycle
    input  logic             iBypassEn,   // consumer may take a word straight from the input
    output logic             oWord_ready,
    output logic             oFire,       // handshake this cycle
    output logic             oAvail,      // a word is available to the consumer this cycle
    output logic [WIDTH-1:0] oWord
);

    logic             bufFull;
    logic [WIDTH-1:0] bufData;
    logic             bypass;

    assign oWord_ready = iEnable && !bufFull && iRoom;
    assign oFire       = iWord_valid && oWord_ready;
    // oFire already implies the buffer is empty, so this is a pure pass-through.
    assign bypass      = iBypassEn && oFire;
    assign oAvail      = bufFull || bypass;
    assign oWord       = bufFull ? bufData : iWord_data;

    // Occupancy flag: set on a buffered handshake, cleared when the consumer takes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bufFull <= 1'b0;
        end else if (oFire && !bypass) begin
            // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
            bufFull <= 1'b1;
        end else if (iTake && bufFull) begin
            bufFull <= 1'b0;
        end
    end

    // Word storage; only captured when the word is not bypassed.
    always_ff @(posedge clk) begin
        // NOTE: data storage has no reset; bufFull qualifies it, which keeps the wide register cheap.
        if (oFire && !bypass) begin
            bufData <= iWord_data;
        end
    end

endmodule

// File: rtl/lstm_init_streamer.sv
// Host-side transmitter: takes 256-bit init words over valid/ready and
// serialises them MSB byte first onto the LSTM core's init byte port,
// then waits for the core to confirm initialisation.
module lstm_init_streamer
    import lstm_host_pkg::*;
#(
    parameter int W_WORDS      = LSTM_W_WORDS,
    parameter int B_WORDS      = LSTM_B_WORDS,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         iStart,
    input  logic         iWord_valid,
    input  logic [255:0] iWord_data,
    output logic         oWord_ready,
    output logic         oInit_valid,
    output logic [7:0]   oInit_data,
    input  logic         iInit_done,
    output logic         oBusy,
    output logic         oDone,
    output logic         oErr
);

    localparam int TOTAL = W_WORDS + B_WORDS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int TW    = $clog2(DONE_TIMEOUT + 1);
    localparam int BW    = $clog2(INIT_BYTES_PER_WORD);

    localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_WORD = CW'(TOTAL - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(INIT_BYTES_PER_WORD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(DONE_TIMEOUT - 1);

    init_state_t   state;
    init_state_t   nextState;

    logic [255:0]  sh;
    logic [BW-1:0] bcnt;
    logic [CW-1:0] wsent;
    logic [CW-1:0] wacc;
    logic [TW-1:0] tcnt;

    logic          wordEn;
    logic          room;
    logic          lastByte;
    logic          lastWord;
    logic          bypassEn;
    logic          take;
    logic          fire;
    logic          avail;
    logic [255:0]  word;

    assign wordEn   = (state == PREFETCH) || (state == STREAM);
    assign room     = (wacc < TOTAL_C);
    assign lastByte = (state == STREAM) && (bcnt == LAST_BYTE);
    assign lastWord = (wsent == LAST_WORD);
    assign bypassEn = lastByte && !lastWord;
    assign take     = ((state == PREFETCH) || bypassEn) && avail;

    lstm_init_word_buf #(
        .WIDTH (256)
    ) u_word_buf (
        .clk         (clk),
        .resetn      (resetn),
        .iEnable     (wordEn),
        .iRoom       (room),
        .iWord_valid (iWord_valid),
        .iWord_data  (iWord_data),
        .iTake       (take),
        .iBypassEn   (bypassEn),
        .oWord_ready (oWord_ready),
        .oFire       (fire),
        .oAvail      (avail),
        .oWord       (word)
    );

    // Outputs decode straight from the state register, so reset clears them at once.
    assign oInit_valid = (state == STREAM);
    assign oInit_data  = oInit_valid ? sh[255:248] : 8'h00;
    assign oBusy       = (state == PREFETCH) || (state == STREAM) || (state == WAIT_DONE);
    assign oDone       = (state == DONE);
    assign oErr        = (state == ERR);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns nextState and no latch is inferred.
        nextState = state;
        case (state)
            IDLE: begin
                if (iStart) begin
                    nextState = iInit_done ? DONE : PREFETCH;
                end
            end
            PREFETCH: begin
                if (avail) begin
                    nextState = STREAM;
                end
            end
            STREAM: begin
                if (lastByte) begin
                    if (lastWord) begin
                        nextState = WAIT_DONE;
                    end else if (!avail) begin
                        nextState = ERR;
                    end
                end
            end
            WAIT_DONE: begin
                if (iInit_done) begin
                    nextState = DONE;
                end else if (tcnt == TMO_LAST) begin
                    nextState = ERR;
                end
            end
            DONE:    nextState = DONE;
            ERR:     nextState = ERR;
            default: nextState = IDLE;
        endcase
    end

    // Shifter and stream counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh    <= '0;
            bcnt  <= '0;
            wsent <= '0;
            tcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bcnt  <= '0;
                    wsent <= '0;
                    tcnt  <= '0;
                end
                PREFETCH: begin
                    if (avail) begin
                        sh    <= word;
                        bcnt  <= '0;
                        wsent <= '0;
                    end
                end
                STREAM: begin
                    sh   <= {sh[247:0], 8'h00};
                    bcnt <= bcnt + BW'(1);
                    if (lastByte) begin
                        if (lastWord) begin
                            tcnt <= '0;
                        end else if (avail) begin
                            sh    <= word;
                            wsent <= wsent + CW'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    tcnt <= tcnt + TW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Accepted-word counter; bounds how many host words are ever taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wacc <= '0;
        end else if (fire) begin
            wacc <= wacc + CW'(1);
        end
    end

endmodule

// File: tb/tb_lstm_init_streamer.sv
// Directed self-checking bench for lstm_init_streamer (2 weight + 1 bias word).
module tb_lstm_init_streamer;

    localparam int W_WORDS      = 2;
    localparam int B_WORDS      = 1;
    localparam int DONE_TIMEOUT = 16;
    localparam int TOTAL        = W_WORDS + B_WORDS;
    localparam int NBYTES       = TOTAL * 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         iStart = 1'b0;
    logic         iWord_valid = 1'b0;
    logic [255:0] iWord_data = '0;
    logic         oWord_ready;
    logic         oInit_valid;
    logic [7:0]   oInit_data;
    logic         iInit_done = 1'b0;
    logic         oBusy;
    logic         oDone;
    logic         oErr;

    int tests = 0;
    int fails = 0;

    // Results of the last runStream call.
    int rBytes;
    int rFirst;
    int rHs;
    int rEnd;
    bit rAborted;

    lstm_init_streamer #(
        .W_WORDS      (W_WORDS),
        .B_WORDS      (B_WORDS),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iStart      (iStart),
        .iWord_valid (iWord_valid),
        .iWord_data  (iWord_data),
        .oWord_ready (oWord_ready),
        .oInit_valid (oInit_valid),
        .oInit_data  (oInit_data),
        .iInit_done  (iInit_done),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oErr        (oErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        resetn      = 1'b0;
        iStart      = 1'b0;
        iWord_valid = 1'b0;
        iInit_done  = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Word idx carries bytes 32*idx+k, MSB byte (k=0) first.
    function automatic logic [255:0] mkWord(input int idx);
        logic [255:0] w;
        for (int k = 0; k < 32; k++) begin
            w[255-8*k -: 8] = 8'(32 * idx + k);
        end
        return w;
    endfunction

    // Starts a stream and plays the host side.
    // mode 0: words always valid; mode 1: word1 only in the byte-31 cycle of word0;
    // mode 2: only word0 is ever offered. abortAt >= 0 asserts reset during that byte.
    task automatic runStream(input int mode, input int abortAt);
        int byteIdx  = 0;
        int nextWord = 0;
        int cyc      = 0;
        bit fin      = 1'b0;
        bit want;
        rHs = -1; rFirst = -1; rEnd = -1; rAborted = 1'b0;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int n = 0; n < 400 && !fin; n++) begin
            cyc++;
            if (oInit_valid) begin
                if (rFirst < 0) rFirst = cyc;
                check("stream_byte", oInit_data, 32'(byteIdx & 255));
                byteIdx++;
                if (abortAt >= 0 && byteIdx == abortAt + 1) begin
                    #2 resetn = 1'b0;
                    #1;
                    check("rst_init_valid", oInit_valid, 0);
                    check("rst_init_data", oInit_data, 0);
                    check("rst_busy", oBusy, 0);
                    check("rst_done", oDone, 0);
                    check("rst_err", oErr, 0);
                    check("rst_word_ready", oWord_ready, 0);
                    rAborted = 1'b1;
                    fin = 1'b1;
                end
            end else begin
                check("idle_data_zero", oInit_data, 0);
                if (rFirst >= 0) begin
                    rEnd = cyc;
                    fin  = 1'b1;
                end
            end
            if (!fin) begin
                case (mode)
                    0:       want = (nextWord < TOTAL);
                    1:       want = (nextWord == 0) || (nextWord == 2) ||
                                    (nextWord == 1 && oInit_valid && byteIdx == 32);
                    default: want = (nextWord == 0);
                endcase
                iWord_valid = want;
                iWord_data  = want ? mkWord(nextWord) : '1;
                if (want && oWord_ready) begin
                    if (nextWord == 0) rHs = cyc;
                    nextWord++;
                end
                tick();
            end
        end
        iWord_valid = 1'b0;
        if (!fin) check("stream_cycle_budget", 0, 1);
        rBytes = byteIdx;
    endtask

    initial begin
        // Reset state.
        #1;
        check("reset_word_ready", oWord_ready, 0);
        check("reset_init_valid", oInit_valid, 0);
        check("reset_init_data", oInit_data, 0);
        check("reset_busy", oBusy, 0);
        check("reset_done", oDone, 0);
        check("reset_err", oErr, 0);
        doReset();
        iWord_valid = 1'b1;
        tick();
        tick();
        check("idle_ignores_word", oWord_ready, 0);
        check("idle_not_busy", oBusy, 0);
        iWord_valid = 1'b0;

        // Nominal stream, then done two cycles into WAIT_DONE; iStart in DONE is ignored.
        runStream(0, -1);
        check("nom_bytes", rBytes, NBYTES);
        check("nom_contiguous", rEnd - rFirst, NBYTES);
        check("nom_latency", rFirst - rHs, 2);
        check("nom_wait_busy", oBusy, 1);
        check("nom_wait_err", oErr, 0);
        check("nom_wait_done", oDone, 0);
        check("nom_wait_ready", oWord_ready, 0);
        tick();
        tick();
        iInit_done = 1'b1;
        tick();
        iInit_done = 1'b0;
        check("nom_done", oDone, 1);
        check("nom_done_busy", oBusy, 0);
        check("nom_done_err", oErr, 0);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        tick();
        check("done_sticky", oDone, 1);
        check("done_restart_ignored", oBusy, 0);

        // Bypass boundary: word1 only in the byte-31 cycle.
        doReset();
        runStream(1, -1);
        check("byp_bytes", rBytes, NBYTES);
        check("byp_contiguous", rEnd - rFirst, NBYTES);
        check("byp_err", oErr, 0);
        check("byp_wait_busy", oBusy, 1);

        // Underflow: only word0 supplied.
        doReset();
        runStream(2, -1);
        check("ufl_bytes", rBytes, 32);
        check("ufl_valid_low", oInit_valid, 0);
        check("ufl_err", oErr, 1);
        check("ufl_busy", oBusy, 0);
        iWord_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ufl_ready_low", oWord_ready, 0);
        end
        iWord_valid = 1'b0;
        check("ufl_err_sticky", oErr, 1);

        // Already initialised: done at start.
        doReset();
        iInit_done  = 1'b1;
        iStart      = 1'b1;
        iWord_valid = 1'b1;
        tick();
        iStart = 1'b0;
        check("pre_done", oDone, 1);
        check("pre_busy", oBusy, 0);
        for (int i = 0; i < 4; i++) begin
            check("pre_ready_low", oWord_ready, 0);
            check("pre_valid_low", oInit_valid, 0);
            tick();
        end
        iInit_done  = 1'b0;
        iWord_valid = 1'b0;

        // Timeout: no done after a full stream.
        doReset();
        runStream(0, -1);
        check("tmo_bytes", rBytes, NBYTES);
        for (int i = 1; i < DONE_TIMEOUT; i++) begin
            check("tmo_err_early", oErr, 0);
            tick();
        end
        check("tmo_err_last_wait", oErr, 0);
        tick();
        check("tmo_err", oErr, 1);
        check("tmo_done", oDone, 0);
        check("tmo_busy", oBusy, 0);

        // Reset mid-stream during byte 10, then a full restart from word 0 byte 0.
        doReset();
        runStream(0, 10);
        check("abort_taken", rAborted, 1);
        tick();
        resetn = 1'b1;
        tick();
        runStream(0, -1);
        check("restart_bytes", rBytes, NBYTES);
        check("restart_contiguous", rEnd - rFirst, NBYTES);
        check("restart_latency", rFirst - rHs, 2);
        check("restart_err", oErr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
